// File: rtl/serial_subtractor_pkg.sv
// Shared types for the digit-serial subtractor: FSM state encoding and a
// constant-function helper for sizing the digit counter.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int ceil_log2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/serial_subtractor_sub_digit.sv
// Combinational W-bit ripple full-subtractor, one digit of the serial datapath.
// c_msb_in is the borrow entering the top bit, used for signed overflow.
module sub_digit
  import serial_sub_pkg::*;
#(
  parameter int W = 1
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic         c,
  output logic [W-1:0] d,
  output logic         c_out,
  output logic         c_msb_in
);

  logic bw;

  always_comb begin
    bw       = c;
    d        = '0;
    c_msb_in = c;
    for (int i = 0; i < W; i++) begin
      if (i == W - 1) c_msb_in = bw;
      d[i] = x[i] ^ y[i] ^ bw;
      bw   = (~x[i] & y[i]) | (~(x[i] ^ y[i]) & bw);
    end
    c_out = bw;
  end

endmodule

// File: rtl/serial_subtractor.sv
// Digit-serial a - b - bin, WIDTH/DIGIT cycles per op; out_valid is held until out_ready.
// Signed overflow output is built only with SERIAL_SUB_OVF_EN defined, otherwise ovf is 0.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  localparam int NDIG  = WIDTH / DIGIT;
  localparam int CNT_W = (NDIG > 1) ? ceil_log2(NDIG) : 1;

  if (WIDTH < 1 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_cfg
    $error("serial_subtractor: DIGIT must divide WIDTH and both must be >= 1");
  end

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d, diff_q, diff_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               brw_q, brw_d, bout_q, bout_d;

  logic [DIGIT-1:0]   dig;
  logic [WIDTH-1:0]   dig_ext;
  logic               dig_c_out, dig_c_msb_in;

  sub_digit #(.W(DIGIT)) u_digit (
    .x        (a_q[DIGIT-1:0]),
    .y        (b_q[DIGIT-1:0]),
    .c        (brw_q),
    .d        (dig),
    .c_out    (dig_c_out),
    .c_msb_in (dig_c_msb_in)
  );

  assign dig_ext = WIDTH'(dig);

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    diff_d  = diff_q;
    cnt_d   = cnt_q;
    brw_d   = brw_q;
    bout_d  = bout_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          brw_d   = bin;
          cnt_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        // Result digits enter at the top so the LSB digit lands at bit 0 after NDIG shifts.
        diff_d = (diff_q >> DIGIT) | (dig_ext << (WIDTH - DIGIT));
        a_d    = a_q >> DIGIT;
        b_d    = b_q >> DIGIT;
        brw_d  = dig_c_out;
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(NDIG - 1)) begin
          bout_d  = dig_c_out;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      diff_q  <= '0;
      cnt_q   <= '0;
      brw_q   <= 1'b0;
      bout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      diff_q  <= diff_d;
      cnt_q   <= cnt_d;
      brw_q   <= brw_d;
      bout_q  <= bout_d;
    end
  end

`ifdef SERIAL_SUB_OVF_EN
  logic ovf_q, ovf_d;

  always_comb begin
    ovf_d = ovf_q;
    if (state_q == BUSY && cnt_q == CNT_W'(NDIG - 1)) ovf_d = dig_c_msb_in ^ dig_c_out;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ovf_q <= 1'b0;
    else     ovf_q <= ovf_d;
  end

  assign ovf = ovf_q;
`else
  logic ovf_unused;
  assign ovf_unused = dig_c_msb_in;
  assign ovf        = 1'b0;
`endif

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign diff      = diff_q;
  assign bout      = bout_q;

endmodule
